uart_loopback_buf: RTL and testbench

Parametrised byte-stream buffer placed between the USB UART's host-to-device pipe and its device-to-host pipe. It replaces direct loopback wiring with a FIFO of configurable width and depth. It adds selectable data modes (echo, invert, sink, pattern generator), wrapping transfer counters and a retriggerable activity strobe for the RGB LED driver. It sits at the top level next to the USB UART and the reset generator.

---
 rtl/uart_loopback_buf_pkg.sv | 11 +
 rtl/uart_loopback_buf_sync_fifo.sv | 51 +++++
 rtl/uart_loopback_buf.sv | 115 +++++++++++
 tb/tb_uart_loopback_buf.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loopback_buf_pkg.sv
// Shared definitions for the UART loopback buffer: data-mode encodings.
package uart_loopback_buf_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_SINK   = 2'd2,
    MODE_GEN    = 2'd3
  } mode_e;

endpackage

// File: rtl/uart_loopback_buf_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; output shows the head entry, zero when empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    level    = wr_ptr_q - rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    // Gating with empty keeps the output at zero after reset without clearing the array.
    pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_loopback_buf.sv
// Byte-stream buffer between the USB UART pipes: mode mux, FIFO, transfer counters, activity strobe.
module uart_loopback_buf
  import uart_loopback_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ACT_W  = 20,
  parameter int CNT_W  = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LW-1:0]     level,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic              activity
);

  mode_e             mode_s;
  logic              fifo_full, fifo_empty;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              rx_fire, tx_fire, gen_push;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]  rx_q, rx_d, tx_q, tx_d;
  logic [ACT_W-1:0]  act_q, act_d;

  assign mode_s = mode_e'(mode);

  always_comb begin
    in_ready  = 1'b0;
    push      = 1'b0;
    push_data = '0;
    gen_push  = 1'b0;
    if (!reset) begin
      case (mode_s)
        MODE_ECHO: begin
          in_ready  = !fifo_full;
          push      = in_valid && !fifo_full;
          push_data = in_data;
        end
        MODE_INVERT: begin
          in_ready  = !fifo_full;
          push      = in_valid && !fifo_full;
          push_data = ~in_data;
        end
        MODE_SINK: begin
          in_ready = 1'b1;
        end
        MODE_GEN: begin
          in_ready  = 1'b1;
          gen_push  = !fifo_full;
          push      = gen_push;
          push_data = pat_q;
        end
        default: ;
      endcase
    end

    out_valid = !fifo_empty;
    rx_fire   = in_valid && in_ready;
    tx_fire   = out_valid && out_ready && !reset;
    pat_d     = pat_q + {{(DATA_W-1){1'b0}}, gen_push};
    rx_d      = rx_q + {{(CNT_W-1){1'b0}}, rx_fire};
    tx_d      = tx_q + {{(CNT_W-1){1'b0}}, tx_fire};
    if (rx_fire || tx_fire) begin
      act_d = '1;
    end else if (act_q != '0) begin
      act_d = act_q - 1'b1;
    end else begin
      act_d = act_q;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      pat_q <= '0;
      rx_q  <= '0;
      tx_q  <= '0;
      act_q <= '0;
    end else begin
      pat_q <= pat_d;
      rx_q  <= rx_d;
      tx_q  <= tx_d;
      act_q <= act_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk_48mhz),
    .srst      (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (tx_fire),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign rx_count = rx_q;
  assign tx_count = tx_q;
  assign activity = (act_q != '0);

endmodule

// File: tb/tb_uart_loopback_buf.sv
// Randomised, self-checking bench for uart_loopback_buf against a queue-based reference model.
module tb_uart_loopback_buf;
  import uart_loopback_buf_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ACT_W  = 4;
  localparam int CNT_W  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk_48mhz = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  rx_count;
  logic [CNT_W-1:0]  tx_count;
  logic              activity;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_48mhz = ~clk_48mhz;

  uart_loopback_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ACT_W  (ACT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .activity  (activity)
  );

  // Reference model: state after the upcoming edge, computed half a cycle early.
  logic [DATA_W-1:0] byte_q [$];
  logic [DATA_W-1:0] exp_out [$];
  logic [DATA_W-1:0] dut_out [$];
  int                m_rx = 0;
  int                m_tx = 0;
  int                m_act = 0;
  logic [DATA_W-1:0] m_pat = '0;

  always @(negedge clk_48mhz) begin
    int sz;
    logic rdy, acc, pp;
    if (reset) begin
      byte_q.delete();
      m_rx  = 0;
      m_tx  = 0;
      m_act = 0;
      m_pat = '0;
    end else begin
      sz  = byte_q.size();
      rdy = (mode == MODE_ECHO || mode == MODE_INVERT) ? (sz < DEPTH) : 1'b1;
      acc = in_valid && rdy;
      pp  = (sz > 0) && out_ready;
      if (pp) begin
        exp_out.push_back(byte_q.pop_front());
        m_tx++;
      end
      if (acc) m_rx++;
      case (mode)
        MODE_ECHO:   if (acc) byte_q.push_back(in_data);
        MODE_INVERT: if (acc) byte_q.push_back(~in_data);
        MODE_GEN: begin
          if (sz < DEPTH) begin
            byte_q.push_back(m_pat);
            m_pat = m_pat + 8'd1;
          end
        end
        default: ;
      endcase
      m_act = (acc || pp) ? (2**ACT_W - 1) : (m_act > 0 ? m_act - 1 : 0);
    end
  end

  always @(negedge clk_48mhz) begin
    if (!reset && out_valid === 1'b1 && out_ready) dut_out.push_back(out_data);
  end

  function automatic logic exp_ready();
    if (reset) return 1'b0;
    return (mode == MODE_ECHO || mode == MODE_INVERT) ? (byte_q.size() < DEPTH) : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_48mhz);
    #2;
  endtask

  task automatic drain();
    int guard = 0;
    mode      = MODE_ECHO;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (out_valid && guard < 64) begin
      tick();
      guard++;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: out_valid=%0b required 0", out_valid);
    end
    tick();
    exp_out.delete();
    dut_out.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = MODE_ECHO; in_data = 8'h5C; in_valid = 1'b1; out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || level !== '0 ||
        rx_count !== '0 || tx_count !== '0 || activity !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b ov=%0b od=%0h lvl=%0d rx=%0d tx=%0d act=%0b required all zero",
               in_ready, out_valid, out_data, level, rx_count, tx_count, activity);
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    exp_out.delete();
    dut_out.delete();
  endtask

  task automatic test_echo();
    logic [7:0] b;
    logic [7:0] seq [3];
    seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
    mode = MODE_ECHO; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = seq[i];
      in_data = b; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== b) begin
        n_fail++;
        $display("FAIL echo_latency[%0d]: ov=%0b data=%0h required ov=1 data=%0h", i, out_valid, out_data, b);
      end
    end
    in_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (rx_count !== 16'd3 || tx_count !== 16'd3 || level !== '0) begin
      n_fail++;
      $display("FAIL echo_counts: rx=%0d tx=%0d lvl=%0d required 3 3 0", rx_count, tx_count, level);
    end
  endtask

  task automatic test_full();
    int idx = 0;
    int guard = 0;
    logic [7:0] base;
    base = 8'($urandom);
    drain();
    mode = MODE_ECHO; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = base + 8'(idx);
      #1;
      if (in_ready) idx++;
      tick();
    end
    n_checks++;
    if (idx != 16 || in_ready !== 1'b0 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL full_stop: accepted=%0d rdy=%0b lvl=%0d required 16 0 16", idx, in_ready, level);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_bypass: rdy=%0b required 0", in_ready);
    end
    while (dut_out.size() < 20 && guard < 100) begin
      in_valid = (idx < 20); in_data = base + 8'(idx);
      #1;
      if (in_valid && in_ready) idx++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (dut_out.size() != 20) begin
      n_fail++;
      $display("FAIL full_drain_count: got %0d bytes required 20", dut_out.size());
    end
    for (int k = 0; k < dut_out.size() && k < 20; k++) begin
      n_checks++;
      if (dut_out[k] !== base + 8'(k)) begin
        n_fail++;
        $display("FAIL full_order[%0d]: got %0h required %0h", k, dut_out[k], base + 8'(k));
      end
    end
  endtask

  task automatic test_invert();
    logic [7:0] vin  [2];
    logic [7:0] vout [2];
    vin[0] = 8'h00; vin[1] = 8'hA5; vout[0] = 8'hFF; vout[1] = 8'h5A;
    drain();
    mode = MODE_INVERT; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = vin[i]; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== vout[i]) begin
        n_fail++;
        $display("FAIL invert[%0d]: ov=%0b data=%0h required ov=1 data=%0h", i, out_valid, out_data, vout[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sink();
    int rx0;
    drain();
    rx0 = m_rx;
    mode = MODE_SINK; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL sink_ready[%0d]: got %0b required 1", i, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sink_out_valid[%0d]: got %0b required 0", i, out_valid);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (rx_count !== 16'(rx0 + 5) || activity !== 1'b1) begin
      n_fail++;
      $display("FAIL sink_counts: rx=%0d act=%0b required rx=%0d act=1", rx_count, activity, 16'(rx0 + 5));
    end
  endtask

  task automatic test_gen();
    int sent = 0;
    int guard = 0;
    int n;
    logic [7:0] eb [4];
    drain();
    for (int i = 0; i < 4; i++) eb[i] = 8'($urandom);
    mode = MODE_GEN;
    for (int c = 0; c < 600; c++) begin
      out_ready = c[0];
      tick();
    end
    mode = MODE_ECHO;
    while (!(sent == 4 && !out_valid) && guard < 300) begin
      out_ready = guard[0];
      in_valid = (sent < 4); in_data = eb[sent & 3];
      #1;
      if (in_valid && in_ready) sent++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    n = dut_out.size();
    n_checks++;
    if (sent != 4 || n < 264) begin
      n_fail++;
      $display("FAIL gen_volume: echoed=%0d outputs=%0d required 4 and >=264", sent, n);
    end
    for (int k = 0; k < n - 4; k++) begin
      n_checks++;
      if (dut_out[k] !== 8'(k)) begin
        n_fail++;
        $display("FAIL gen_seq[%0d]: got %0h required %0h", k, dut_out[k], 8'(k));
      end
    end
    for (int k = 0; k < 4 && n >= 4; k++) begin
      n_checks++;
      if (dut_out[n - 4 + k] !== eb[k]) begin
        n_fail++;
        $display("FAIL gen_then_echo[%0d]: got %0h required %0h", k, dut_out[n - 4 + k], eb[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int high = 0;
    drain();
    mode = MODE_ECHO; out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1;
      tick();
    end
    n_checks++;
    if (level !== 5'd7) begin
      n_fail++;
      $display("FAIL rst_mid_level_before: got %0d required 7", level);
    end
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %0b required 0", in_ready);
    end
    tick();
    reset = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (level !== '0 || out_valid !== 1'b0 || out_data !== 8'h00 || rx_count !== '0 ||
        tx_count !== '0 || activity !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: lvl=%0d ov=%0b od=%0h rx=%0d tx=%0d act=%0b required all zero",
               level, out_valid, out_data, rx_count, tx_count, activity);
    end
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || dut_out.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: ov=%0b outputs=%0d required 0 0", out_valid, dut_out.size());
    end
    in_data = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (activity !== (m_act != 0)) begin
        n_fail++;
        $display("FAIL activity_decay[%0d]: got %0b required %0b", c, activity, (m_act != 0));
      end
      if (activity === 1'b1) high++;
      tick();
    end
    n_checks++;
    if (activity !== 1'b0 || high != 2**ACT_W - 1) begin
      n_fail++;
      $display("FAIL activity_length: act=%0b high_cycles=%0d required 0 and %0d", activity, high, 2**ACT_W - 1);
    end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      mode      = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== exp_ready() || out_valid !== (byte_q.size() > 0) ||
          out_data !== (byte_q.size() > 0 ? byte_q[0] : 8'h00) || level !== 5'(byte_q.size()) ||
          rx_count !== 16'(m_rx) || tx_count !== 16'(m_tx) || activity !== (m_act != 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: rdy=%0b ov=%0b od=%0h lvl=%0d rx=%0d tx=%0d act=%0b required %0b %0b %0h %0d %0d %0d %0b",
                 c, in_ready, out_valid, out_data, level, rx_count, tx_count, activity,
                 exp_ready(), (byte_q.size() > 0), (byte_q.size() > 0 ? byte_q[0] : 8'h00),
                 byte_q.size(), 16'(m_rx), 16'(m_tx), (m_act != 0));
      end
      tick();
    end
    in_valid = 1'b0;
    mode = MODE_ECHO;
    tick();
    n_checks++;
    if (dut_out.size() != exp_out.size()) begin
      n_fail++;
      $display("FAIL random_out_count: got %0d required %0d", dut_out.size(), exp_out.size());
    end
    for (int k = 0; k < dut_out.size() && k < exp_out.size(); k++) begin
      n_checks++;
      if (dut_out[k] !== exp_out[k]) begin
        n_fail++;
        $display("FAIL random_out[%0d]: got %0h required %0h", k, dut_out[k], exp_out[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = MODE_ECHO; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_echo();
    test_full();
    test_invert();
    test_sink();
    test_gen();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
